uart_loader: RTL and testbench

- Sits directly downstream of uart_rx.
- Turns the received byte stream into memory writes, so a host can download PRG/CHR images over the FTDI link.
- Parses a framed packet: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CHK.
- Drives a simple synchronous write port, and reports done, checksum-error and timeout status to the system controller.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_byte_strobe.sv | 19 +
 rtl/uart_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_* blocks.
package uart_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR_H = 3'd1,
      ST_ADDR_L = 3'd2,
      ST_LEN_H  = 3'd3,
      ST_LEN_L  = 3'd4,
      ST_DATA   = 3'd5,
      ST_CHECK  = 3'd6
   } loader_state_t;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the uart_rx byte-ready level into a single-cycle strobe per byte.
module uart_byte_strobe (
   input  logic clk,
   input  logic reset,
   input  logic uart_valid,
   output logic rx_stb
);

   logic uart_valid_q;

   // Resets high so a level already asserted at reset release is not a new byte.
   always_ff @(posedge clk) begin
      if (reset) uart_valid_q <= 1'b1;
      else       uart_valid_q <= uart_valid;
   end

   assign rx_stb = uart_valid & ~uart_valid_q;

endmodule

// File: rtl/uart_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from uart_rx into memory writes,
// with checksum and inter-byte timeout status.
module uart_loader
   import uart_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
   parameter int unsigned TIMEOUT_CLKS = 2_147_700,
   parameter int unsigned TO_W         = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_valid,
   input  logic [7:0]  uart_DI,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        busy,
   output logic        done,
   output logic        err_chk,
   output logic        err_timeout
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned BYTE_W = 8;

   loader_state_t state, state_nxt;

   logic              rx_stb;
   logic              timeout_hit;
   logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
   logic [BYTE_W-1:0] chk_acc, chk_acc_nxt;
   logic [BYTE_W-1:0] addr_h, addr_h_nxt;
   logic [BYTE_W-1:0] len_h, len_h_nxt;
   logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
   logic [LEN_W-1:0]  remaining, remaining_nxt;
   logic [LEN_W-1:0]  len_full;
   logic              mem_we_nxt, done_nxt, busy_nxt;
   logic              err_chk_nxt, err_timeout_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [BYTE_W-1:0] mem_data_nxt;

   uart_byte_strobe u_strobe (
      .clk        (clk),
      .reset      (reset),
      .uart_valid (uart_valid),
      .rx_stb     (rx_stb)
   );

   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign timeout_hit = (state != ST_IDLE) && !rx_stb &&
                        (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
   assign len_full    = {len_h, uart_DI};

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout_hit) begin
         state_nxt = ST_IDLE;
      end else if (rx_stb) begin
         case (state)
            ST_IDLE:   if (uart_DI == SYNC_BYTE) state_nxt = ST_ADDR_H;
            ST_ADDR_H: state_nxt = ST_ADDR_L;
            ST_ADDR_L: state_nxt = ST_LEN_H;
            ST_LEN_H:  state_nxt = ST_LEN_L;
            ST_LEN_L:  state_nxt = (len_full != '0) ? ST_DATA : ST_CHECK;
            ST_DATA:   if (remaining == LEN_W'(1)) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      to_cnt_nxt      = to_cnt;
      chk_acc_nxt     = chk_acc;
      addr_h_nxt      = addr_h;
      len_h_nxt       = len_h;
      cur_addr_nxt    = cur_addr;
      remaining_nxt   = remaining;
      mem_we_nxt      = 1'b0;
      mem_addr_nxt    = mem_addr;
      mem_data_nxt    = mem_data;
      done_nxt        = 1'b0;
      err_chk_nxt     = err_chk;
      err_timeout_nxt = err_timeout;
      busy_nxt        = (state_nxt != ST_IDLE);

      if (state == ST_IDLE || rx_stb || timeout_hit) to_cnt_nxt = '0;
      else                                            to_cnt_nxt = to_cnt + TO_W'(1);

      if (timeout_hit) err_timeout_nxt = 1'b1;

      if (rx_stb) begin
         case (state)
            ST_IDLE: begin
               if (uart_DI == SYNC_BYTE) begin
                  err_chk_nxt     = 1'b0;
                  err_timeout_nxt = 1'b0;
                  chk_acc_nxt     = '0;
               end
            end
            ST_ADDR_H: begin
               addr_h_nxt  = uart_DI;
               chk_acc_nxt = chk_acc + uart_DI;
            end
            ST_ADDR_L: begin
               cur_addr_nxt = {addr_h, uart_DI};
               chk_acc_nxt  = chk_acc + uart_DI;
            end
            ST_LEN_H: begin
               len_h_nxt   = uart_DI;
               chk_acc_nxt = chk_acc + uart_DI;
            end
            ST_LEN_L: begin
               remaining_nxt = len_full;
               chk_acc_nxt   = chk_acc + uart_DI;
            end
            ST_DATA: begin
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = cur_addr;
               mem_data_nxt  = uart_DI;
               chk_acc_nxt   = chk_acc + uart_DI;
               cur_addr_nxt  = cur_addr + ADDR_W'(1);
               remaining_nxt = remaining - LEN_W'(1);
            end
            ST_CHECK: begin
               if (uart_DI == chk_acc) done_nxt    = 1'b1;
               else                    err_chk_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt      <= '0;
         chk_acc     <= '0;
         addr_h      <= '0;
         len_h       <= '0;
         cur_addr    <= '0;
         remaining   <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_data    <= '0;
         done        <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         to_cnt      <= to_cnt_nxt;
         chk_acc     <= chk_acc_nxt;
         addr_h      <= addr_h_nxt;
         len_h       <= len_h_nxt;
         cur_addr    <= cur_addr_nxt;
         remaining   <= remaining_nxt;
         mem_we      <= mem_we_nxt;
         mem_addr    <= mem_addr_nxt;
         mem_data    <= mem_data_nxt;
         done        <= done_nxt;
         err_chk     <= err_chk_nxt;
         err_timeout <= err_timeout_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Directed, table-driven bench for uart_loader frame parsing, status and reset.
module tb_uart_loader;

   localparam int unsigned TO_CLKS = 5000;
   localparam int unsigned GAP     = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        uart_valid;
   logic [7:0]  uart_DI;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        busy, done, err_chk, err_timeout;

   uart_loader #(
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TO_CLKS),
      .TO_W         (24)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_valid  (uart_valid),
      .uart_DI     (uart_DI),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .busy        (busy),
      .done        (done),
      .err_chk     (err_chk),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]      addr;
      logic [15:0]      len;
      logic [3:0][7:0]  data;
      logic [7:0]       chk;
      logic [3:0][15:0] exp_addr;
      logic             exp_done;
      logic             exp_err;
   } vec_t;

   vec_t vecs [4];
   int   total    = 0;
   int   passed   = 0;
   int   wr_cnt   = 0;
   int   done_cnt = 0;

   always @(negedge clk) begin
      if (mem_we) wr_cnt++;
      if (done)   done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Sends one byte and checks the write strobe lands exactly one clock after the strobe.
   task automatic send_byte(input logic [7:0] b, input logic exp_we,
                            input logic [15:0] exp_a, input logic [7:0] exp_d);
      logic        we1, we2;
      logic [15:0] a1;
      logic [7:0]  d1;
      @(negedge clk);
      uart_DI    = b;
      uart_valid = 1'b1;
      @(negedge clk);
      we1 = mem_we; a1 = mem_addr; d1 = mem_data;
      @(negedge clk);
      we2 = mem_we;
      @(negedge clk);
      uart_valid = 1'b0;
      repeat (GAP) @(negedge clk);
      check("we_latency", 32'(we1), 32'(exp_we));
      if (exp_we) begin
         check("wr_addr", 32'(a1), 32'(exp_a));
         check("wr_data", 32'(d1), 32'(exp_d));
      end
      check("we_one_cycle", 32'(we2), 32'd0);
   endtask

   task automatic apply_vec(input int idx);
      vec_t v;
      int   w0, d0;
      v  = vecs[idx];
      w0 = wr_cnt;
      d0 = done_cnt;
      send_byte(8'hA5, 1'b0, 16'h0, 8'h0);
      check("sync_clr_err_chk", 32'(err_chk), 32'd0);
      check("sync_clr_err_to", 32'(err_timeout), 32'd0);
      check("busy_in_frame", 32'(busy), 32'd1);
      send_byte(v.addr[15:8], 1'b0, 16'h0, 8'h0);
      send_byte(v.addr[7:0],  1'b0, 16'h0, 8'h0);
      send_byte(v.len[15:8],  1'b0, 16'h0, 8'h0);
      send_byte(v.len[7:0],   1'b0, 16'h0, 8'h0);
      for (int k = 0; k < int'(v.len); k++)
         send_byte(v.data[k], 1'b1, v.exp_addr[k], v.data[k]);
      send_byte(v.chk, 1'b0, 16'h0, 8'h0);
      check("frame_writes", 32'(wr_cnt - w0), 32'(v.len));
      check("frame_done", 32'(done_cnt - d0), 32'(v.exp_done));
      check("frame_err_chk", 32'(err_chk), 32'(v.exp_err));
      check("frame_busy_end", 32'(busy), 32'd0);
   endtask

   initial begin
      int w0, d0;
      bit seen_idle;

      vecs[0] = '{addr: 16'h1234, len: 16'd3,
                  data: {8'h00, 8'h33, 8'h22, 8'h11}, chk: 8'hAF,
                  exp_addr: {16'h0000, 16'h1236, 16'h1235, 16'h1234},
                  exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{addr: 16'h1234, len: 16'd3,
                  data: {8'h00, 8'h33, 8'h22, 8'h11}, chk: 8'h00,
                  exp_addr: {16'h0000, 16'h1236, 16'h1235, 16'h1234},
                  exp_done: 1'b0, exp_err: 1'b1};
      vecs[2] = '{addr: 16'hFFFE, len: 16'd4,
                  data: {8'h04, 8'h03, 8'h02, 8'h01}, chk: 8'h0B,
                  exp_addr: {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE},
                  exp_done: 1'b1, exp_err: 1'b0};
      vecs[3] = '{addr: 16'h0010, len: 16'd0,
                  data: '0, chk: 8'h10,
                  exp_addr: '0,
                  exp_done: 1'b1, exp_err: 1'b0};

      reset      = 1'b1;
      uart_valid = 1'b0;
      uart_DI    = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", 32'(mem_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err_chk", 32'(err_chk), 32'd0);
      check("rst_err_to", 32'(err_timeout), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Good frame, bad checksum (sticky until next SYNC), address wrap.
      for (int i = 0; i < 3; i++) begin
         apply_vec(i);
         if (i == 1) begin
            repeat (20) @(negedge clk);
            check("err_chk_sticky", 32'(err_chk), 32'd1);
         end
      end

      // Garbage before SYNC is ignored, then a zero-length frame.
      w0 = wr_cnt;
      send_byte(8'h00, 1'b0, 16'h0, 8'h0);
      send_byte(8'hFF, 1'b0, 16'h0, 8'h0);
      send_byte(8'h5A, 1'b0, 16'h0, 8'h0);
      check("garbage_busy", 32'(busy), 32'd0);
      check("garbage_writes", 32'(wr_cnt - w0), 32'd0);
      apply_vec(3);

      // Inter-byte timeout after one data byte.
      w0 = wr_cnt;
      d0 = done_cnt;
      send_byte(8'hA5, 1'b0, 16'h0, 8'h0);
      send_byte(8'h00, 1'b0, 16'h0, 8'h0);
      send_byte(8'h00, 1'b0, 16'h0, 8'h0);
      send_byte(8'h00, 1'b0, 16'h0, 8'h0);
      send_byte(8'h02, 1'b0, 16'h0, 8'h0);
      send_byte(8'h55, 1'b1, 16'h0000, 8'h55);
      repeat (TO_CLKS - 200) @(negedge clk);
      check("to_not_early_busy", 32'(busy), 32'd1);
      check("to_not_early_err", 32'(err_timeout), 32'd0);
      seen_idle = 1'b0;
      for (int c = 0; c < 400 && !seen_idle; c++) begin
         @(negedge clk);
         if (!busy) seen_idle = 1'b1;
      end
      check("to_returns_idle", 32'(seen_idle), 32'd1);
      check("to_err_set", 32'(err_timeout), 32'd1);
      check("to_one_write", 32'(wr_cnt - w0), 32'd1);
      check("to_no_done", 32'(done_cnt - d0), 32'd0);
      apply_vec(0);

      // uart_valid held high across reset release must not create a byte.
      @(negedge clk);
      reset      = 1'b1;
      uart_DI    = 8'hA5;
      uart_valid = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("valid_hi_rst_busy", 32'(busy), 32'd0);
      uart_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the DATA phase, with a byte arriving alongside it.
      w0 = wr_cnt;
      send_byte(8'hA5, 1'b0, 16'h0, 8'h0);
      send_byte(8'h20, 1'b0, 16'h0, 8'h0);
      send_byte(8'h00, 1'b0, 16'h0, 8'h0);
      send_byte(8'h00, 1'b0, 16'h0, 8'h0);
      send_byte(8'h08, 1'b0, 16'h0, 8'h0);
      send_byte(8'hC1, 1'b1, 16'h2000, 8'hC1);
      send_byte(8'hC2, 1'b1, 16'h2001, 8'hC2);
      check("pre_rst_busy", 32'(busy), 32'd1);
      @(negedge clk);
      reset      = 1'b1;
      uart_DI    = 8'h77;
      uart_valid = 1'b1;
      @(negedge clk);
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_we", 32'(mem_we), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      uart_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_rst_writes", 32'(wr_cnt - w0), 32'd2);
      check("mid_rst_done", 32'(done), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
